// File: rtl/alu_arbiter.sv
// Two-requester front end for a registered ALU: grants one request, holds its operands,
// captures the result and flags, and presents them until consumed.
// Optional macro ALU_ARB_ROUND_ROBIN_EN selects alternating grants instead of fixed req0 priority.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic [OPW-1:0]   req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_csig,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             alu_v,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic [2:0]       rsp_flags,
  output logic             busy
);

  localparam logic [OPW-1:0] OP_CLEAR = OPW'(4'b1011);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_anyValid;
  logic             w_accept;
  logic             w_grant1;
  logic [WIDTH-1:0] r_aluA;
  logic [WIDTH-1:0] r_aluB;
  logic [OPW-1:0]   r_aluCsig;
  logic             r_rspId;
  logic [WIDTH-1:0] r_rspResult;
  logic [2:0]       r_rspFlags;

  assign w_anyValid = req0_valid | req1_valid;
  assign w_accept   = (r_state == IDLE) & w_anyValid;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic r_lastGrant;

  // On contention, grant whichever requester did not win last time.
  always_comb begin
    w_grant1 = req1_valid & (~req0_valid | ~r_lastGrant);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_lastGrant <= 1'b1;
    else if (w_accept) r_lastGrant <= w_grant1;
  end
`else
  always_comb begin
    w_grant1 = req1_valid & ~req0_valid;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_anyValid) w_next = ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = w_accept & ~w_grant1;
    req1_ready = w_accept & w_grant1;
    busy       = (r_state != IDLE);
    rsp_valid  = (r_state == RESP);
  end

  // Operands are latched only at grant, so later input changes cannot reach the ALU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aluA      <= '0;
      r_aluB      <= '0;
      r_aluCsig   <= OP_CLEAR;
      r_rspId     <= 1'b0;
      r_rspResult <= '0;
      r_rspFlags  <= 3'b000;
    end else if (w_accept) begin
      r_aluA    <= w_grant1 ? req1_a  : req0_a;
      r_aluB    <= w_grant1 ? req1_b  : req0_b;
      r_aluCsig <= w_grant1 ? req1_op : req0_op;
      r_rspId   <= w_grant1;
    end else if (r_state == WAIT) begin
      r_rspResult <= alu_out;
      r_rspFlags  <= {alu_v, alu_n, alu_z};
      r_aluA      <= '0;
      r_aluB      <= '0;
      r_aluCsig   <= OP_CLEAR;
    end
  end

  assign alu_a      = r_aluA;
  assign alu_b      = r_aluB;
  assign alu_csig   = r_aluCsig;
  assign rsp_id     = r_rspId;
  assign rsp_result = r_rspResult;
  assign rsp_flags  = r_rspFlags;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a registered ALU model in the loop.
// Grant-order expectations follow ALU_ARB_ROUND_ROBIN_EN when the build defines it.
module tb_alu_arbiter;
  localparam int WIDTH = 32;
  localparam int OPW   = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req1_valid, req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [OPW-1:0]   req0_op, req1_op;
  logic [WIDTH-1:0] alu_a, alu_b, alu_out;
  logic [OPW-1:0]   alu_csig;
  logic             alu_z, alu_n, alu_v;
  logic             rsp_valid, rsp_ready, rsp_id, busy;
  logic [WIDTH-1:0] rsp_result;
  logic [2:0]       rsp_flags;

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic [2:0]  flags;
    int          acc;
  } sbItem_t;

  sbItem_t sb[$];
  int      grants[$];
  int      total = 0;
  int      bad   = 0;
  int      cycle = 0;
  logic [34:0] aluReg = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_csig(alu_csig),
    .alu_out(alu_out), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
  );

  // Reference ALU: returns {v, n, z, result}
  function automatic logic [34:0] aluFn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    logic [31:0] res;
    logic        v;
    res = '0;
    v   = 1'b0;
    case (op)
      4'b0110: begin res = a + b; v = (a[31] == b[31]) && (res[31] != a[31]); end
      4'b0101: begin res = a - b; v = (a[31] != b[31]) && (res[31] != a[31]); end
      4'b0000: res = a & b;
      4'b0001: res = a | b;
      default: res = '0;
    endcase
    return {v, ($signed(a) < $signed(b)), (res == 32'd0), res};
  endfunction

  // Registered ALU in the loop, sampling the arbiter's operands every edge
  always @(posedge clk) aluReg <= aluFn(alu_a, alu_b, alu_csig);
  assign alu_out = aluReg[31:0];
  assign alu_z   = aluReg[32];
  assign alu_n   = aluReg[33];
  assign alu_v   = aluReg[34];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  task automatic pushReq(input logic id, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    logic [34:0] f;
    f = aluFn(a, b, op);
    grants.push_back(int'(id));
    sb.push_back('{id, f[31:0], f[34:32], cycle});
  endtask

  // Monitor: scoreboard pushes on acceptance, pops on response handshake
  logic        prevValid = 1'b0, prevReady = 1'b0, heldId = 1'b0;
  logic [31:0] heldRes = '0;
  logic [2:0]  heldFlags = '0;

  initial begin
    sbItem_t item;
    forever begin
      @(negedge clk);
      #1;
      if (req0_ready && req1_ready) checkOutput("dualReady", 64'd1, 64'd0);
      if (busy) checkOutput("readyWhileBusy", 64'({req0_ready, req1_ready}), 64'd0);
      if (req0_ready) pushReq(1'b0, req0_a, req0_b, req0_op);
      if (req1_ready) pushReq(1'b1, req1_a, req1_b, req1_op);
      if (prevValid && prevReady) checkOutput("rspDrop", 64'(rsp_valid), 64'd0);
      if (rsp_valid && !prevValid) begin
        if (sb.size() == 0) checkOutput("unexpRsp", 64'd1, 64'd0);
        else                checkOutput("latency", 64'(cycle), 64'(sb[0].acc + 3));
      end
      if (rsp_valid && prevValid && !prevReady) begin
        checkOutput("stableRes", 64'(rsp_result), 64'(heldRes));
        checkOutput("stableId", 64'(rsp_id), 64'(heldId));
        checkOutput("stableFlags", 64'(rsp_flags), 64'(heldFlags));
      end
      if (rsp_valid && rsp_ready && sb.size() > 0) begin
        item = sb.pop_front();
        checkOutput("rspId", 64'(rsp_id), 64'(item.id));
        checkOutput("rspResult", 64'(rsp_result), 64'(item.res));
        checkOutput("rspFlags", 64'(rsp_flags), 64'(item.flags));
      end
      prevValid = rsp_valid;
      prevReady = rsp_ready;
      heldRes   = rsp_result;
      heldId    = rsp_id;
      heldFlags = rsp_flags;
    end
  end

  // Drive one request and return at the negedge of the ISSUE cycle with inputs scrambled
  task automatic applyStimulus(input logic port, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    int n;
    logic rdy;
    @(negedge clk);
    if (!port) begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
    else       begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
    n = 0;
    #1;
    rdy = port ? req1_ready : req0_ready;
    while (!rdy && n < 20) begin
      @(negedge clk);
      #1;
      rdy = port ? req1_ready : req0_ready;
      n++;
    end
    if (!rdy) checkOutput("acceptTimeout", 64'd0, 64'd1);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = $urandom; req0_b = $urandom; req0_op = 4'($urandom);
    req1_a = $urandom; req1_b = $urandom; req1_op = 4'($urandom);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    @(negedge clk);
    #1;
    while (busy && n < 30) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (busy) checkOutput("idleTimeout", 64'd1, 64'd0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_rspValid"}, 64'(rsp_valid), 64'd0);
    checkOutput({tag, "_rspId"}, 64'(rsp_id), 64'd0);
    checkOutput({tag, "_rspResult"}, 64'(rsp_result), 64'd0);
    checkOutput({tag, "_rspFlags"}, 64'(rsp_flags), 64'd0);
    checkOutput({tag, "_aluA"}, 64'(alu_a), 64'd0);
    checkOutput({tag, "_aluB"}, 64'(alu_b), 64'd0);
    checkOutput({tag, "_aluCsig"}, 64'(alu_csig), 64'hb);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] opList [4];
    int expGrants [4];
    int n;
    opList = '{4'b0110, 4'b0101, 4'b0000, 4'b0001};
`ifdef ALU_ARB_ROUND_ROBIN_EN
    expGrants = '{0, 1, 0, 1};
`else
    expGrants = '{0, 0, 0, 0};
`endif
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    repeat (2) @(negedge clk);
    #1;
    checkResetState("reset");
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] single req0 add 5+3");
    applyStimulus(1'b0, 32'd5, 32'd3, 4'b0110);
    #1;
    checkOutput("issueA", 64'(alu_a), 64'd5);
    checkOutput("issueB", 64'(alu_b), 64'd3);
    checkOutput("issueOp", 64'(alu_csig), 64'h6);
    checkOutput("issueBusy", 64'(busy), 64'd1);
    @(negedge clk);
    #1;
    checkOutput("waitA", 64'(alu_a), 64'd5);
    checkOutput("waitOp", 64'(alu_csig), 64'h6);
    @(negedge clk);
    #1;
    checkOutput("respValid", 64'(rsp_valid), 64'd1);
    checkOutput("respClearOp", 64'(alu_csig), 64'hb);
    checkOutput("respClearA", 64'(alu_a), 64'd0);
    checkOutput("respClearB", 64'(alu_b), 64'd0);
    waitIdle();

    $display("[TB] req0 signed overflow add");
    applyStimulus(1'b0, 32'h7fffffff, 32'd1, 4'b0110);
    waitIdle();

    $display("[TB] single req1 sub 7-7");
    applyStimulus(1'b1, 32'd7, 32'd7, 4'b0101);
    waitIdle();

    $display("[TB] both requesters valid continuously");
    grants.delete();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = $urandom_range(0, 1000); req0_b = $urandom_range(0, 1000);
      req1_a = $urandom_range(0, 1000); req1_b = $urandom_range(0, 1000);
      req0_op = opList[$urandom_range(0, 3)];
      req1_op = opList[$urandom_range(0, 3)];
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    waitIdle();
    checkOutput("grantCount", 64'(grants.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("grant%0d", i), 64'((i < grants.size()) ? grants[i] : -1), 64'(expGrants[i]));

    $display("[TB] response backpressure");
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 32'd100, 32'd58, 4'b0101);
    req0_valid = 1'b1; req1_valid = 1'b1;
    n = 0;
    #1;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!rsp_valid) checkOutput("rspTimeout", 64'd0, 64'd1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("holdValid", 64'(rsp_valid), 64'd1);
      checkOutput("holdBusy", 64'(busy), 64'd1);
      checkOutput("holdReady", 64'({req0_ready, req1_ready}), 64'd0);
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    waitIdle();

    $display("[TB] reset during WAIT");
    applyStimulus(1'b1, 32'd9, 32'd4, 4'b0110);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    checkResetState("midReset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      checkOutput("postResetValid", 64'(rsp_valid), 64'd0);
    end

    grants.delete();
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    waitIdle();
    checkOutput("postResetGrant", 64'((grants.size() > 0) ? grants[0] : -1), 64'd0);
    checkOutput("sbEmpty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
